// File: rtl/tip_hello_memtest_pkg.sv
// Shared types and constants for the AXI memory-test master.
// Holds the FSM encoding, fixed AXI field values and the per-lane data pattern.
package tip_hello_memtest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_FIN
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_16B   = 3'd4;
  localparam int         LANES          = 4;

  // Lane j of beat k carries seed + 4k + j, wrapping mod 2^32.
  function automatic logic [31:0] lane_pattern(input logic [31:0] seed,
                                               input logic [31:0] k,
                                               input logic [1:0]  lane);
    return seed + {k[29:0], 2'b00} + {30'd0, lane};
  endfunction

endpackage

// File: rtl/tip_hello_memtest_pattern.sv
// Combinational beat generator: (seed, beat index) -> 128-bit expected beat.
// One instance serves both the write data path and the read-back compare.
module tip_hello_memtest_pattern
  import tip_hello_memtest_pkg::*;
(
  input  logic [31:0]  seed,
  input  logic [31:0]  beat_idx,
  output logic [127:0] beat_data
);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign beat_data[32*gi +: 32] = lane_pattern(seed, beat_idx, 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/tip_hello_axi_memtest_master.sv
// AXI4 memory-test initiator: writes a seeded pattern in fixed INCR bursts,
// reads it back one burst at a time and tallies mismatching beats.
module tip_hello_axi_memtest_master
  import tip_hello_memtest_pkg::*;
#(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 128,
  parameter int BW_AXI_TID = 4,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BW_ADDR-1:0]    base_addr,
  input  logic [15:0]           num_burst,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [BW_ADDR-1:0]    first_err_addr,
  output logic [BW_AXI_TID-1:0] txawid,
  output logic [BW_ADDR-1:0]    txawaddr,
  output logic [7:0]            txawlen,
  output logic [2:0]            txawsize,
  output logic [1:0]            txawburst,
  output logic                  txawvalid,
  input  logic                  txawready,
  output logic [BW_AXI_TID-1:0] txwid,
  output logic [BW_DATA-1:0]    txwdata,
  output logic [BW_DATA/8-1:0]  txwstrb,
  output logic                  txwlast,
  output logic                  txwvalid,
  input  logic                  txwready,
  input  logic [BW_AXI_TID-1:0] txbid,
  input  logic [1:0]            txbresp,
  input  logic                  txbvalid,
  output logic                  txbready,
  output logic [BW_AXI_TID-1:0] txarid,
  output logic [BW_ADDR-1:0]    txaraddr,
  output logic [7:0]            txarlen,
  output logic [2:0]            txarsize,
  output logic [1:0]            txarburst,
  output logic                  txarvalid,
  input  logic                  txarready,
  input  logic [BW_AXI_TID-1:0] txrid,
  input  logic [BW_DATA-1:0]    txrdata,
  input  logic [1:0]            txrresp,
  input  logic                  txrlast,
  input  logic                  txrvalid,
  output logic                  txrready
);

  localparam logic [BW_ADDR-1:0] BURST_BYTES = BW_ADDR'(16 * BURST_LEN);
  localparam logic [8:0]         LAST_BEAT   = 9'(BURST_LEN - 1);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [15:0]         err_q, err_d;
  logic [BW_ADDR-1:0]  first_err_q, first_err_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                wlast_q, wlast_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [BW_ADDR-1:0]  addr_q, addr_d;
  logic [BW_ADDR-1:0]  base_q, base_d;
  logic [31:0]         seed_q, seed_d;
  logic [15:0]         nburst_q, nburst_d;
  logic [15:0]         burst_q, burst_d;
  logic [8:0]          beat_q, beat_d;
  logic [31:0]         k_q, k_d;

  logic [127:0]        pat_data;
  logic [BW_ADDR-1:0]  beat_addr;
  logic                is_last_beat;
  logic                last_burst;
  logic                r_bad;
  logic                err_hit;
  logic [BW_ADDR-1:0]  err_addr;
  logic                unused_inputs;

  // k_q is the global beat index of the current phase, so the same generator
  // produces write data and read-back expectations.
  tip_hello_memtest_pattern u_pattern (
    .seed      (seed_q),
    .beat_idx  (k_q),
    .beat_data (pat_data)
  );

  assign beat_addr    = base_q + (BW_ADDR'(k_q) << 4);
  assign is_last_beat = (beat_q == LAST_BEAT);
  assign last_burst   = ((burst_q + 16'd1) == nburst_q);
  assign r_bad        = (txrdata != pat_data) || (txrresp != AXI_RESP_OKAY) ||
                        (txrlast != is_last_beat);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    wlast_d     = wlast_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    base_d      = base_q;
    seed_d      = seed_q;
    nburst_d    = nburst_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
    k_d         = k_q;
    err_hit     = 1'b0;
    err_addr    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = {base_addr[BW_ADDR-1:4], 4'b0000};
          addr_d      = {base_addr[BW_ADDR-1:4], 4'b0000};
          seed_d      = seed;
          nburst_d    = num_burst;
          burst_d     = '0;
          beat_d      = '0;
          k_d         = '0;
          err_d       = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          if (num_burst == 16'd0) begin
            state_d = ST_FIN;
          end else begin
            state_d   = ST_AW;
            awvalid_d = 1'b1;
          end
        end
      end
      ST_AW: begin
        if (txawready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wlast_d   = (LAST_BEAT == 9'd0);
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (wvalid_q && txwready) begin
          k_d     = k_q + 32'd1;
          beat_d  = beat_q + 9'd1;
          wlast_d = ((beat_q + 9'd1) == LAST_BEAT);
          if (is_last_beat) begin
            beat_d   = '0;
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = ST_B;
          end
        end
      end
      ST_B: begin
        if (txbvalid) begin
          bready_d = 1'b0;
          if (txbresp != AXI_RESP_OKAY) begin
            err_hit  = 1'b1;
            err_addr = addr_q;
          end
          // The read phase restarts at the region base with beat index 0.
          if (last_burst) begin
            state_d   = ST_AR;
            arvalid_d = 1'b1;
            burst_d   = '0;
            k_d       = '0;
            addr_d    = base_q;
          end else begin
            state_d   = ST_AW;
            awvalid_d = 1'b1;
            burst_d   = burst_q + 16'd1;
            addr_d    = addr_q + BURST_BYTES;
          end
        end
      end
      ST_AR: begin
        if (txarready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (txrvalid) begin
          if (r_bad) begin
            err_hit  = 1'b1;
            err_addr = beat_addr;
          end
          k_d    = k_q + 32'd1;
          beat_d = beat_q + 9'd1;
          // Burst end follows our own beat count, not the slave's rlast.
          if (is_last_beat) begin
            beat_d   = '0;
            rready_d = 1'b0;
            if (last_burst) begin
              state_d = ST_FIN;
            end else begin
              state_d   = ST_AR;
              arvalid_d = 1'b1;
              burst_d   = burst_q + 16'd1;
              addr_d    = addr_q + BURST_BYTES;
            end
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == 16'd0);
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_hit) begin
      err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
      if (err_q == 16'd0) begin
        first_err_d = err_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      first_err_q <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      base_q      <= '0;
      seed_q      <= '0;
      nburst_q    <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      k_q         <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      seed_q      <= seed_d;
      nburst_q    <= nburst_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      k_q         <= k_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_err_q;

  assign txawid    = '0;
  assign txawaddr  = addr_q;
  assign txawlen   = 8'(BURST_LEN - 1);
  assign txawsize  = AXI_SIZE_16B;
  assign txawburst = AXI_BURST_INCR;
  assign txawvalid = awvalid_q;

  assign txwid     = '0;
  assign txwdata   = wvalid_q ? pat_data : '0;
  assign txwstrb   = '1;
  assign txwlast   = wlast_q;
  assign txwvalid  = wvalid_q;

  assign txbready  = bready_q;

  assign txarid    = '0;
  assign txaraddr  = addr_q;
  assign txarlen   = 8'(BURST_LEN - 1);
  assign txarsize  = AXI_SIZE_16B;
  assign txarburst = AXI_BURST_INCR;
  assign txarvalid = arvalid_q;

  assign txrready  = rready_q;

  assign unused_inputs = ^{txbid, txrid, base_addr[3:0]};

endmodule

// File: tb/tb_tip_hello_axi_memtest_master.sv
// Bench for the AXI memory-test master: behavioural AXI slave with fault
// injection, a scenario table, randomized scenarios and reset corner cases.
module tb_tip_hello_axi_memtest_master;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [15:0]  num_burst;
  logic [31:0]  seed;
  logic         busy, done, pass;
  logic [15:0]  err_count;
  logic [31:0]  first_err_addr;
  logic [3:0]   txawid, txwid, txarid, txbid, txrid;
  logic [31:0]  txawaddr, txaraddr;
  logic [7:0]   txawlen, txarlen;
  logic [2:0]   txawsize, txarsize;
  logic [1:0]   txawburst, txarburst, txbresp, txrresp;
  logic         txawvalid, txawready, txwlast, txwvalid, txwready;
  logic         txbvalid, txbready, txarvalid, txarready;
  logic         txrlast, txrvalid, txrready;
  logic [127:0] txwdata, txrdata;
  logic [15:0]  txwstrb;

  always #5 clk = ~clk;

  tip_hello_axi_memtest_master #(
    .BW_ADDR(32), .BW_DATA(128), .BW_AXI_TID(4), .BURST_LEN(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_burst(num_burst), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .txawid(txawid), .txawaddr(txawaddr), .txawlen(txawlen), .txawsize(txawsize),
    .txawburst(txawburst), .txawvalid(txawvalid), .txawready(txawready),
    .txwid(txwid), .txwdata(txwdata), .txwstrb(txwstrb), .txwlast(txwlast),
    .txwvalid(txwvalid), .txwready(txwready),
    .txbid(txbid), .txbresp(txbresp), .txbvalid(txbvalid), .txbready(txbready),
    .txarid(txarid), .txaraddr(txaraddr), .txarlen(txarlen), .txarsize(txarsize),
    .txarburst(txarburst), .txarvalid(txarvalid), .txarready(txarready),
    .txrid(txrid), .txrdata(txrdata), .txrresp(txrresp), .txrlast(txrlast),
    .txrvalid(txrvalid), .txrready(txrready)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Scenario configuration read by the slave model.
  int          case_id = 0;
  int          cfg_flip_k = -1;
  int          cfg_slverr_b = -1;
  bit          cfg_stall = 0;
  logic [31:0] cfg_seed = '0;
  logic [31:0] cfg_base = '0;

  // Counters owned by the slave model, cleared on each new case_id.
  int           aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit           any_active;
  logic [127:0] first_wdata;

  logic [127:0] mem [logic [27:0]];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_beat(input logic [31:0] sd, input int k);
    logic [127:0] d;
    for (int j = 0; j < 4; j++) d[32*j +: 32] = sd + 32'(4 * k + j);
    return d;
  endfunction

  // Write errors come first in time, so a bad bresp wins first_err_addr.
  function automatic void model_expect(input logic [31:0] base, input int flip_k,
                                       input int slv_b, output int e_err,
                                       output logic [31:0] e_first);
    e_err   = 0;
    e_first = '0;
    if (slv_b >= 0) begin
      e_err++;
      e_first = base + 32'(256 * slv_b);
    end
    if (flip_k >= 0) begin
      if (e_err == 0) e_first = base + 32'(16 * flip_k);
      e_err++;
    end
  endfunction

  // Behavioural slave: at negedge it sees the handshakes of the coming edge,
  // just after the edge it updates its own valids/readies.
  initial begin : slave
    int           seen_case;
    bit           rst_seen, aw_f, w_f, b_f, ar_f, r_f;
    bit           aw_hold, w_hold, ar_hold, b_pending, r_active;
    logic [31:0]  h_awaddr, h_araddr, wr_addr, rd_addr;
    logic [127:0] h_wdata;
    logic         h_wlast;
    int           w_beat, r_beat;
    seen_case = -1;
    aw_hold = 0; w_hold = 0; ar_hold = 0; b_pending = 0; r_active = 0;
    w_beat = 0; r_beat = 0; wr_addr = '0; rd_addr = '0;
    h_awaddr = '0; h_araddr = '0; h_wdata = '0; h_wlast = 0;
    txawready = 0; txwready = 0; txbvalid = 0; txbresp = 0; txbid = 0;
    txarready = 0; txrvalid = 0; txrdata = '0; txrresp = 0; txrlast = 0; txrid = 0;
    forever begin
      @(negedge clk);
      if (seen_case != case_id) begin
        seen_case = case_id;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; any_active = 0;
      end
      rst_seen = rst;
      aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0;
      if (rst_seen) begin
        aw_hold = 0; w_hold = 0; ar_hold = 0; b_pending = 0; r_active = 0;
        w_beat = 0; r_beat = 0;
      end else begin
        aw_f = txawvalid && txawready;
        w_f  = txwvalid && txwready;
        b_f  = txbvalid && txbready;
        ar_f = txarvalid && txarready;
        r_f  = txrvalid && txrready;
        if (txawvalid || txwvalid || txbready || txarvalid || txrready) any_active = 1;
        if (aw_hold) check("aw_hold", {txawvalid, txawaddr}, {1'b1, h_awaddr});
        if (w_hold)  check("w_hold", {txwvalid, txwlast, txwdata}, {1'b1, h_wlast, h_wdata});
        if (ar_hold) check("ar_hold", {txarvalid, txaraddr}, {1'b1, h_araddr});
        aw_hold = txawvalid && !txawready; h_awaddr = txawaddr;
        w_hold  = txwvalid && !txwready;   h_wdata = txwdata; h_wlast = txwlast;
        ar_hold = txarvalid && !txarready; h_araddr = txaraddr;
        if (aw_f) begin
          check($sformatf("awaddr b%0d", aw_cnt), txawaddr, cfg_base + 32'(256 * aw_cnt));
          check("aw_fields", {txawid, txawlen, txawsize, txawburst},
                {4'd0, 8'd15, 3'd4, 2'b01});
          wr_addr = txawaddr;
          w_beat  = 0;
          aw_cnt++;
        end
        if (w_f) begin
          check($sformatf("wdata k%0d", w_cnt), txwdata, model_beat(cfg_seed, w_cnt));
          check($sformatf("wlast k%0d", w_cnt), {txwlast, txwstrb}, {w_beat == 15, 16'hFFFF});
          if (w_cnt == 0) first_wdata = txwdata;
          mem[wr_addr[31:4] + 28'(w_beat)] = txwdata;
          w_beat++;
          w_cnt++;
          if (w_beat == 16) begin
            b_pending = 1;
            w_beat    = 0;
          end
        end
        if (b_f) b_cnt++;
        if (ar_f) begin
          check($sformatf("araddr b%0d", ar_cnt), txaraddr, cfg_base + 32'(256 * ar_cnt));
          check("ar_fields", {txarid, txarlen, txarsize, txarburst},
                {4'd0, 8'd15, 3'd4, 2'b01});
          rd_addr  = txaraddr;
          r_beat   = 0;
          r_active = 1;
          ar_cnt++;
        end
        if (r_f) begin
          r_beat++;
          r_cnt++;
          if (r_beat == 16) r_active = 0;
        end
      end
      @(posedge clk);
      #1;
      if (rst_seen) begin
        txawready = 0; txwready = 0; txarready = 0; txbvalid = 0; txrvalid = 0;
        txrlast = 0;
      end else begin
        txawready = cfg_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        txwready  = cfg_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        txarready = cfg_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (b_f) txbvalid = 0;
        if (b_pending && !txbvalid && (!cfg_stall || $urandom_range(0, 1) == 1)) begin
          txbvalid  = 1;
          txbresp   = (b_cnt == cfg_slverr_b) ? 2'b10 : 2'b00;
          b_pending = 0;
        end
        if (r_f) txrvalid = 0;
        if (r_active && !txrvalid && (!cfg_stall || $urandom_range(0, 1) == 1)) begin
          txrvalid = 1;
          txrdata  = mem[rd_addr[31:4] + 28'(r_beat)];
          if (r_cnt == cfg_flip_k) txrdata[0] = ~txrdata[0];
          txrresp  = 2'b00;
          txrlast  = (r_beat == 15);
        end
      end
    end
  end

  task automatic run_case(input int id, input int nb, input logic [31:0] sd,
                          input logic [31:0] base, input int flip_k, input int slv_b,
                          input bit stall, input int exp_err, input logic [31:0] exp_first);
    int cyc;
    bit got;
    @(negedge clk);
    cfg_flip_k = flip_k; cfg_slverr_b = slv_b; cfg_stall = stall;
    cfg_seed = sd; cfg_base = base;
    case_id++;
    @(negedge clk);
    start = 1; num_burst = 16'(nb); seed = sd; base_addr = base;
    @(posedge clk);
    #1;
    start = 0;
    check($sformatf("v%0d busy_after_start", id), busy, 1'b1);
    check($sformatf("v%0d awvalid_after_start", id), txawvalid, nb != 0);
    cyc = 1;
    got = 0;
    while (cyc < 20000 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1;
    end
    check($sformatf("v%0d done_seen", id), got, 1'b1);
    if (nb == 0) begin
      check($sformatf("v%0d done_latency", id), cyc, 2);
      check($sformatf("v%0d no_traffic", id), any_active, 1'b0);
    end
    check($sformatf("v%0d pass", id), pass, exp_err == 0);
    check($sformatf("v%0d err_count", id), err_count, exp_err);
    check($sformatf("v%0d first_err_addr", id), first_err_addr, exp_first);
    check($sformatf("v%0d busy_at_done", id), busy, 1'b0);
    check($sformatf("v%0d counts", id), {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt},
          {nb, nb * 16, nb, nb, nb * 16});
    $display("case v%0d: nb=%0d seed=%0h base=%0h -> err=%0d first=%0h pass=%0d",
             id, nb, sd, base, err_count, first_err_addr, pass);
    @(posedge clk);
    #1;
    check($sformatf("v%0d done_pulse", id), {done, pass}, {1'b0, exp_err == 0});
  endtask

  typedef struct {
    int          nb;
    logic [31:0] sd;
    logic [31:0] base;
    int          flip_k;
    int          slv_b;
    bit          stall;
    int          exp_err;
    logic [31:0] exp_first;
  } vec_t;

  vec_t         vecs[7];
  logic [127:0] beat0_exp;

  initial begin
    rst = 1; start = 0; base_addr = '0; num_burst = '0; seed = '0;
    vecs[0] = '{2, 32'h1000,     32'h0,    -1, -1, 0, 0, 32'h0};
    vecs[1] = '{2, 32'h1000,     32'h0,    21, -1, 0, 1, 32'h150};
    vecs[2] = '{2, 32'h1000,     32'h0,    -1, -1, 1, 0, 32'h0};
    vecs[3] = '{0, 32'h1000,     32'h0,    -1, -1, 0, 0, 32'h0};
    vecs[4] = '{2, 32'h1000,     32'h2000, -1,  0, 0, 1, 32'h2000};
    vecs[5] = '{3, 32'hFFFFFFF0, 32'h7F00,  0,  2, 1, 2, 32'h8100};
    vecs[6] = '{1, 32'hDEADBEEF, 32'h300,  15, -1, 0, 1, 32'h3F0};
    beat0_exp = 128'h00001003_00001002_00001001_00001000;

    repeat (3) @(posedge clk);
    #1;
    check("reset_status", {busy, done, pass, err_count, first_err_addr}, '0);
    check("reset_valids", {txawvalid, txwvalid, txbready, txarvalid, txrready}, '0);
    check("reset_payload", {txawaddr, txaraddr, txwdata}, '0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 7; i++) begin
      run_case(i, vecs[i].nb, vecs[i].sd, vecs[i].base, vecs[i].flip_k,
               vecs[i].slv_b, vecs[i].stall, vecs[i].exp_err, vecs[i].exp_first);
      if (i == 0) check("beat0_data", first_wdata, beat0_exp);
    end

    for (int i = 0; i < 8; i++) begin
      int          nb, fk, sb, e_err;
      logic [31:0] sd, base, e_first;
      nb   = int'($urandom_range(1, 4));
      sd   = $urandom;
      base = $urandom & 32'h000F_FF00;
      fk   = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, nb * 16 - 1));
      sb   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      model_expect(base, fk, sb, e_err, e_first);
      run_case(100 + i, nb, sd, base, fk, sb, 1'($urandom_range(0, 1)), e_err, e_first);
    end

    // Reset while the master is presenting W beat 7 of burst 0.
    begin
      int  cyc;
      bit  got;
      @(negedge clk);
      cfg_flip_k = -1; cfg_slverr_b = -1; cfg_stall = 0;
      cfg_seed = 32'h55; cfg_base = 32'h400;
      case_id++;
      @(negedge clk);
      start = 1; num_burst = 16'd2; seed = 32'h55; base_addr = 32'h400;
      @(negedge clk);
      start = 0;
      cyc = 0;
      got = 0;
      while (cyc < 200 && !got) begin
        @(posedge clk);
        #2;
        cyc++;
        if (w_cnt == 7) got = 1;
      end
      check("rst_mid_reached_beat7", {got, txwvalid}, {1'b1, 1'b1});
      rst = 1;
      @(posedge clk);
      #1;
      check("rst_mid_valids", {txawvalid, txwvalid, txbready, txarvalid, txrready}, '0);
      check("rst_mid_busy", busy, 1'b0);
      @(negedge clk);
      rst = 0;
    end
    run_case(200, 2, 32'h1000, 32'h0, -1, -1, 0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
